// File: rtl/if_prefetch_queue_pkg.sv
// if_pkg: shared fetch-entry type, counter-width helper and reset PC for the prefetch front end
package if_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/if_sync_fifo.sv
// if_sync_fifo: synchronous FIFO with clear, occupancy count and full/empty flags
module if_sync_fifo import if_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        clear_i,
  input  logic [WIDTH-1:0]            data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  // Pointer and count advance; clear discards everything, including a same-cycle push
  always_comb begin
    wr_d  = clear_i ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d  = clear_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    cnt_d = clear_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // Pointer and count registers
  always_ff @(posedge clk) begin
    wr_q  <= resetn ? wr_d : '0;
    rd_q  <= resetn ? rd_d : '0;
    cnt_q <= resetn ? cnt_d : '0;
  end
  // Storage needs no reset; only entries below count are ever read out
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: pipelined instruction fetch with in-flight PC tracking and an instruction queue ahead of ID; define IF_ADEF_CHECK_EN to turn misaligned fetch PCs into a single adef entry
module if_prefetch_queue import if_pkg::*; #(
  parameter int          OUTSTANDING = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs2ds_valid,
  output logic [31:0] fs2ds_pc,
  output logic [31:0] fs2ds_inst,
  output logic        fs2ds_adef
);
  localparam int CW = cnt_width(OUTSTANDING);
  localparam int FW = cnt_width(FIFO_DEPTH);
  logic [31:0] req_pc_q, req_pc_d;
  logic [CW-1:0] discard_q, discard_d, inflight;
  logic [31:0] occupancy, pcq_pc;
  logic [FW-1:0] fifo_cnt;
  logic pcq_full, pcq_empty, fifo_full, fifo_empty;
  logic accept, misaligned, adef_push, fifo_push, fifo_pop;
  fetch_entry_t fifo_in, fifo_out, head;
  // The PC queue holds exactly the accepted-but-unanswered requests, so its count is inflight
  assign occupancy      = 32'(inflight) + 32'(fifo_cnt);
  assign inst_sram_en   = resetn & ~redirect_valid & ~misaligned & (inflight < CW'(OUTSTANDING)) & (occupancy < 32'(FIFO_DEPTH));
  assign inst_sram_addr = req_pc_q;
  assign accept         = inst_sram_en & inst_sram_addr_ok;
`ifdef IF_ADEF_CHECK_EN
  logic halt_q, halt_d;
  assign misaligned = |req_pc_q[1:0];
  assign adef_push  = misaligned & ~halt_q & ~redirect_valid & (inflight == '0) & (discard_q == '0) & ~fifo_full;
  assign halt_d     = redirect_valid ? 1'b0 : halt_q | adef_push;
  // One adef entry per bad PC; fetch stays parked until a redirect
  always_ff @(posedge clk)
    halt_q <= resetn ? halt_d : 1'b0;
`else
  assign misaligned = 1'b0;
  assign adef_push  = 1'b0;
`endif
  assign fifo_push   = (inst_sram_data_ok & (discard_q == '0)) | adef_push;
  assign fifo_in     = adef_push ? '{pc: req_pc_q, inst: 32'h0, adef: 1'b1} : '{pc: pcq_pc, inst: inst_sram_rdata, adef: 1'b0};
  assign fs2ds_valid = ~fifo_empty & ~redirect_valid;
  assign fifo_pop    = fs2ds_valid & ds_allowin;
  assign head        = fifo_empty ? '0 : fifo_out;
  assign fs2ds_pc    = head.pc;
  assign fs2ds_inst  = head.inst;
  assign fs2ds_adef  = head.adef;
  // Next fetch PC and number of in-flight responses still to be thrown away
  always_comb begin
    req_pc_d  = redirect_valid ? redirect_pc : accept ? req_pc_q + 32'd4 : req_pc_q;
    discard_d = redirect_valid ? inflight - CW'(inst_sram_data_ok) : (inst_sram_data_ok && discard_q != '0) ? discard_q - CW'(1) : discard_q;
  end
  // Fetch PC and discard counter registers
  always_ff @(posedge clk) begin
    req_pc_q  <= resetn ? req_pc_d : RESET_PC;
    discard_q <= resetn ? discard_d : '0;
  end
  if_sync_fifo #(.DEPTH(OUTSTANDING), .WIDTH(32)) u_pc_queue (
    .clk(clk), .resetn(resetn),
    .push_i(accept), .pop_i(inst_sram_data_ok), .clear_i(1'b0),
    .data_i(req_pc_q), .data_o(pcq_pc),
    .count_o(inflight), .full_o(pcq_full), .empty_o(pcq_empty)
  );
  if_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_fifo (
    .clk(clk), .resetn(resetn),
    .push_i(fifo_push), .pop_i(fifo_pop), .clear_i(redirect_valid),
    .data_i(fifo_in), .data_o(fifo_out),
    .count_o(fifo_cnt), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!resetn) inst_sram_data_ok |-> !pcq_empty);
  a_pcq_no_ovf:  assert property (@(posedge clk) disable iff (!resetn) accept |-> !pcq_full);
  a_fifo_no_ovf: assert property (@(posedge clk) disable iff (!resetn) (fifo_push && !redirect_valid) |-> !fifo_full);
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: randomized scoreboard bench with an in-order memory model for if_prefetch_queue
module tb_if_prefetch_queue;
  localparam int OUTSTANDING = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } exp_t;
  typedef struct { logic [31:0] addr; int rdy; } req_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic ds_allowin = 1'b1;
  logic fs2ds_valid, fs2ds_adef;
  logic [31:0] fs2ds_pc, fs2ds_inst;
  int passed = 0, total = 0;
  exp_t exp_q[$];
  req_t pend[$];
  int cyc = 0, last_rdy = 0, lat_min = 1, lat_max = 1, ok_pct = 100;
  int accepts = 0, delivered = 0;

  always #5 clk = ~clk;

  if_prefetch_queue dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ds_allowin(ds_allowin),
    .fs2ds_valid(fs2ds_valid), .fs2ds_pc(fs2ds_pc), .fs2ds_inst(fs2ds_inst), .fs2ds_adef(fs2ds_adef)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // After a redirect or reset, ID must see consecutive PCs from the target with the memory's data
  task automatic expect_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back('{pc + 32'(4 * i), mem_data(pc + 32'(4 * i)), 1'b0});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // In-order SRAM model: drives responses at the falling edge, records accepted requests 2 time units later
  initial begin
    int r;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend.size() > 0 && pend[0].rdy <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = mem_data(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = $urandom;
      end
      inst_sram_addr_ok = $urandom_range(99) < ok_pct;
      #2;
      if (!resetn) begin
        pend.delete();
        last_rdy = 0;
      end else begin
        if (redirect_valid) chk("en_during_redirect", inst_sram_en, 0);
        if (inst_sram_en) chk("en_inflight_limit", (pend.size() + int'(inst_sram_data_ok)) < OUTSTANDING, 1);
        if (inst_sram_en && inst_sram_addr_ok) begin
          r = cyc + int'($urandom_range(lat_max, lat_min));
          if (r <= last_rdy) r = last_rdy + 1;
          last_rdy = r;
          pend.push_back('{inst_sram_addr, r});
          accepts++;
        end
      end
    end
  end

  // Monitor: every ID handshake pops the scoreboard and compares
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (resetn && fs2ds_valid && ds_allowin) begin
      delivered++;
      chk("entry_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fs2ds_pc", fs2ds_pc, e.pc);
        chk("fs2ds_inst", fs2ds_inst, e.inst);
        chk("fs2ds_adef", fs2ds_adef, e.adef);
      end
    end
  end

  initial begin
    int d0, a0;
    bit found;
    repeat (3) step();
    #2;
    chk("rst_en", inst_sram_en, 0);
    chk("rst_addr", inst_sram_addr, RESET_PC);
    chk("rst_valid", fs2ds_valid, 0);
    chk("rst_pc", fs2ds_pc, 0);
    chk("rst_inst", fs2ds_inst, 0);
    chk("rst_adef", fs2ds_adef, 0);
    step();
    resetn = 1'b1;
    expect_stream(RESET_PC);
    #2;
    chk("first_req_en", inst_sram_en, 1);
    chk("first_req_addr", inst_sram_addr, RESET_PC);
    step();
    #2;
    chk("valid_cycle2", fs2ds_valid, 0);
    step();
    #2;
    chk("valid_cycle3", fs2ds_valid, 1);
    chk("first_pc", fs2ds_pc, RESET_PC);
    d0 = delivered;
    repeat (8) step();
    #2;
    chk("throughput_8", delivered - d0, 8);
    step();
    ds_allowin = 1'b0;
    repeat (10) step();
    #2;
    chk("stall_en", inst_sram_en, 0);
    chk("stall_valid", fs2ds_valid, 1);
    chk("stall_queued", accepts - delivered, FIFO_DEPTH);
    step();
    ds_allowin = 1'b1;
    repeat (12) step();
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pend.size() == 2 && !inst_sram_data_ok) found = 1;
    end
    chk("two_in_flight", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0100;
    expect_stream(redirect_pc);
    step();
    redirect_valid = 1'b0;
    repeat (15) step();
    lat_min = 2;
    lat_max = 2;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (inst_sram_data_ok) found = 1;
    end
    chk("redirect_with_data_ok", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0200;
    expect_stream(redirect_pc);
    step();
    redirect_pc = 32'h1c00_0300;
    expect_stream(redirect_pc);
    step();
    redirect_valid = 1'b0;
    repeat (15) step();
    lat_min = 1;
    lat_max = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0102;
`ifdef IF_ADEF_CHECK_EN
    exp_q.delete();
    exp_q.push_back('{32'h1c00_0102, 32'h0, 1'b1});
`else
    expect_stream(redirect_pc);
`endif
    step();
    redirect_valid = 1'b0;
    a0 = accepts;
    repeat (10) step();
    #2;
`ifdef IF_ADEF_CHECK_EN
    chk("adef_no_request", accepts - a0, 0);
    chk("adef_en_low", inst_sram_en, 0);
    chk("adef_entry_seen", exp_q.size(), 0);
`else
    chk("misaligned_issued", (accepts - a0) > 0, 1);
`endif
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0400;
    expect_stream(redirect_pc);
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    lat_min = 1;
    lat_max = 4;
    ok_pct = 70;
    for (int i = 0; i < 500; i++) begin
      step();
      ds_allowin = $urandom_range(99) < 80;
      if ($urandom_range(99) < 5) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0000 + ($urandom_range(1023) << 2);
        expect_stream(redirect_pc);
      end else redirect_valid = 1'b0;
    end
    step();
    redirect_valid = 1'b0;
    ds_allowin = 1'b1;
    ok_pct = 100;
    lat_min = 3;
    lat_max = 3;
    repeat (5) step();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pend.size() > 0) found = 1;
    end
    chk("reset_midburst_inflight", found, 1);
    resetn = 1'b0;
    step();
    #2;
    chk("mid_rst_en", inst_sram_en, 0);
    chk("mid_rst_addr", inst_sram_addr, RESET_PC);
    chk("mid_rst_valid", fs2ds_valid, 0);
    chk("mid_rst_pc", fs2ds_pc, 0);
    chk("mid_rst_inst", fs2ds_inst, 0);
    chk("mid_rst_adef", fs2ds_adef, 0);
    step();
    resetn = 1'b1;
    expect_stream(RESET_PC);
    #2;
    chk("restart_addr", inst_sram_addr, RESET_PC);
    d0 = delivered;
    repeat (20) step();
    #2;
    chk("restart_delivers", delivered > d0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch front end replacing the single-buffer pre-IF/IF pair. It issues up to OUTSTANDING sequential fetch requests on the SRAM-like instruction port and queues returned instructions with their PCs in a FIFO_DEPTH-entry buffer ahead of ID. On a redirect (exception, ertn, taken branch) it flushes the queue and silently discards every response still in flight. Upstream logic resolves redirect priority; this block sees one redirect source.

## Interface
- OUTSTANDING, 2: max accepted-but-unanswered requests (>=1).
- FIFO_DEPTH, 4: instruction queue entries (>= OUTSTANDING, power of two).
- RESET_PC, 32'h1c000000: first fetch address.
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- inst_sram_en  out  1  request valid this cycle.
- inst_sram_addr  out  32  fetch address (req_pc).
- inst_sram_addr_ok  in  1  request accepted (only meaningful with en).
- inst_sram_data_ok  in  1  response valid; responses return in request order.
- inst_sram_rdata  in  32  response data.
- redirect_valid  in  1  single-cycle flush-and-refetch pulse.
- redirect_pc  in  32  new fetch PC.
- ds_allowin  in  1  ID accepts this cycle.
- fs2ds_valid  out  1  head entry offered to ID.
- fs2ds_pc  out  32  head entry PC.
- fs2ds_inst  out  32  head entry instruction.
- fs2ds_adef  out  1  head entry carries fetch-address error.

## Operation
- State: req_pc, inflight (0..OUTSTANDING), discard (0..OUTSTANDING), PC queue (depth OUTSTANDING), instruction FIFO.
- inst_sram_en = ~redirect_valid & (inflight < OUTSTANDING) & (inflight + fifo_count < FIFO_DEPTH). It uses registered counts; a same-cycle pop is not credited. The SRAM bridge treats en as a per-cycle request, so dropping en without addr_ok is legal.
- en & addr_ok: push req_pc to the PC queue, req_pc += 4 (mod 2^32 wrap), inflight += 1.
- data_ok: pop the PC queue, inflight -= 1.
  - If discard != 0: discard -= 1, drop the data.
  - Else: push {pc, rdata, 0} into the FIFO. The reservation rule guarantees no overflow.
- Accept and response in the same cycle: inflight is unchanged.
- fs2ds_valid = fifo_nonempty & ~redirect_valid. Pop on fs2ds_valid & ds_allowin.
- redirect_valid:
  - FIFO cleared.
  - req_pc <= redirect_pc.
  - discard <= inflight - data_ok.
  - inflight <= inflight - data_ok.
  - PC queue keeps in-flight PCs; they pop with their discarded responses.
  - No request is issued that cycle.
  - A redirect while discard != 0 is legal and recomputes discard the same way.
- data_ok with inflight == 0 is a protocol violation (assertion).

## Timing
- Reset values: inst_sram_en 0, inst_sram_addr RESET_PC, fs2ds_valid 0, fs2ds_pc/inst 0, fs2ds_adef 0, inflight 0, discard 0.
- First request is issued the cycle after resetn rises.
- Latency: addr_ok in cycle T, data_ok earliest T+1, fs2ds_valid earliest T+2.
- Redirect in cycle R: first new request in R+1. The first new instruction is visible no earlier than R+3, after the remaining stale responses drain.
- Throughput: 1 instr/cycle sustained when OUTSTANDING>=2, the memory has 1-cycle latency, and ID never stalls.

## Configuration
- IF_ADEF_CHECK_EN defined:
  - A req_pc with bits [1:0] != 0 is never sent to SRAM.
  - Once inflight == 0 and discard == 0, the block pushes one entry {req_pc, 32'h0, adef=1}.
  - Fetch then halts (en 0) until the next redirect.
- Undefined: fs2ds_adef is tied 0, and misaligned addresses are issued as-is.

## Structure
- Shared package if_pkg holds:
  - the fetch-entry struct {pc[31:0], inst[31:0], adef};
  - the counter-width function clog2(OUTSTANDING+1);
  - the default RESET_PC constant.
- Sub-module if_sync_fifo (parameters DEPTH, WIDTH; push/pop/clear, count, full/empty) is instantiated twice: once as the PC queue and once as the instruction FIFO.

## Test plan
- Memory 1-cycle, addr_ok always 1, ds_allowin 1 -> fs2ds_pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles from cycle 3 after reset.
- ds_allowin 0 for 10 cycles -> exactly FIFO_DEPTH (4) entries queued, en 0, no lost or duplicated PC after release.
- Memory latency 3, redirect to 0x1c000100 with 2 requests in flight -> both stale responses dropped, next fs2ds_pc = 0x1c000100.
- Redirect coinciding with data_ok and a second redirect 1 cycle later -> discard counts 1 then 0/1 as computed, only second target's instructions reach ID.
- IF_ADEF_CHECK_EN, redirect_pc 0x1c000102 -> one entry pc 0x1c000102 adef 1, no SRAM request, en stays 0 until next redirect.
- resetn low mid-burst with requests in flight -> all outputs return to reset values the next cycle, fetch restarts at RESET_PC.
